alarm_keypad_ctrl: RTL and testbench

//   PIN-entry keypad front end for the alarm controller. Collects digit strobes and checks the

---
 rtl/alarm_keypad_ctrl_if.sv | 29 ++
 rtl/alarm_keypad_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alarm_keypad_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_keypad_ctrl_if.sv
// Keypad/controller signal bundle for alarm_keypad_ctrl.
//   key_valid, key_code : key strobe and code from the keypad scanner
//   sys_armed           : alarm controller status (1 = armed/triggered/alarm_on)
//   arm_req, disarm_req : one-cycle requests to the alarm controller
//   entry_active        : PIN entry in progress
//   locked_out          : keypad locked after repeated wrong codes
//   fail_cnt            : consecutive wrong-code count
interface alarm_keypad_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       sys_armed;
    logic       arm_req;
    logic       disarm_req;
    logic       entry_active;
    logic       locked_out;
    logic [2:0] fail_cnt;

    // Keypad/controller side: drives keys and status, observes requests.
    modport master (
        output key_valid, key_code, sys_armed,
        input  arm_req, disarm_req, entry_active, locked_out, fail_cnt
    );

    // Keypad front end.
    modport slave (
        input  key_valid, key_code, sys_armed,
        output arm_req, disarm_req, entry_active, locked_out, fail_cnt
    );
endinterface

// File: rtl/alarm_keypad_ctrl.sv
// PIN-entry keypad front end: collects digits, compares against a fixed PIN,
// issues one-cycle arm/disarm requests and enforces a timed lockout after
// repeated wrong codes.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ena   : enable; when low all state holds and keys are dropped
//   kp    : keypad/controller bundle (slave side), see alarm_keypad_ctrl_if
module alarm_keypad_ctrl #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter logic [15:0] PIN            = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned ENTRY_TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    alarm_keypad_ctrl_if.slave  kp
);

    localparam int unsigned BUF_W  = 4 * PIN_DIGITS;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned FAIL_W = 3;
    localparam int unsigned TO_W   = $clog2(ENTRY_TIMEOUT + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [BUF_W-1:0] PIN_CODE = PIN[BUF_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_LOCKOUT
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [TO_W-1:0]     timer_q, timer_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                arm_q, arm_d;
    logic                disarm_q, disarm_d;
    logic                entry_q, entry_d;
    logic                locked_q, locked_d;

    logic                key_c;
    logic                is_digit_c;
    logic                is_enter_c;
    logic                is_clear_c;
    logic                match_c;
    logic [FAIL_W-1:0]   fail_inc_c;

    assign key_c      = kp.key_valid & ena;
    assign is_digit_c = (kp.key_code <= 4'd9);
    assign is_enter_c = (kp.key_code == 4'hA);
    assign is_clear_c = (kp.key_code == 4'hB);
    // Overflow catches codes longer than the PIN even if the last digits match.
    assign match_c    = (cnt_q == CNT_W'(PIN_DIGITS)) & ~ovf_q & (buf_q == PIN_CODE);
    assign fail_inc_c = FAIL_W'(fail_q + FAIL_W'(1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            timer_q  <= '0;
            lock_q   <= '0;
            fail_q   <= '0;
            arm_q    <= 1'b0;
            disarm_q <= 1'b0;
            entry_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            timer_q  <= timer_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
            arm_q    <= arm_d;
            disarm_q <= disarm_d;
            entry_q  <= entry_d;
            locked_q <= locked_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        timer_d  = timer_q;
        lock_d   = lock_q;
        fail_d   = fail_q;
        arm_d    = 1'b0;
        disarm_d = 1'b0;

        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_c && is_digit_c) begin
                        buf_d   = BUF_W'(kp.key_code);
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        timer_d = '0;
                        state_d = ST_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (key_c) begin
                        timer_d = '0;
                        if (is_digit_c) begin
                            // Shift left one nibble; oldest digit falls off the top.
                            buf_d = BUF_W'({buf_q, kp.key_code});
                            if (cnt_q == CNT_W'(PIN_DIGITS)) begin
                                ovf_d = 1'b1;
                            end else begin
                                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                            end
                        end else if (is_enter_c) begin
                            state_d = ST_CHECK;
                        end else if (is_clear_c) begin
                            buf_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else if (timer_q == TO_W'(ENTRY_TIMEOUT - 1)) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = TO_W'(timer_q + TO_W'(1));
                    end
                end

                ST_CHECK: begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    if (match_c) begin
                        fail_d   = '0;
                        arm_d    = ~kp.sys_armed;
                        disarm_d = kp.sys_armed;
                        state_d  = ST_IDLE;
                    end else begin
                        fail_d = fail_inc_c;
                        if (fail_inc_c == FAIL_W'(MAX_FAILS)) begin
                            lock_d  = '0;
                            state_d = ST_LOCKOUT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (lock_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                        lock_d  = '0;
                        fail_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        lock_d = LOCK_W'(lock_q + LOCK_W'(1));
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end

        entry_d  = (state_d == ST_ENTRY);
        locked_d = (state_d == ST_LOCKOUT);
    end

    assign kp.arm_req      = arm_q;
    assign kp.disarm_req   = disarm_q;
    assign kp.entry_active = entry_q;
    assign kp.locked_out   = locked_q;
    assign kp.fail_cnt     = fail_q;

endmodule

// File: tb/tb_alarm_keypad_ctrl.sv
// Self-checking bench for alarm_keypad_ctrl: directed scenarios plus random
// key traffic, all compared every cycle against a digit-queue reference model.
module tb_alarm_keypad_ctrl;

    localparam int unsigned T_PIN_DIGITS = 4;
    localparam logic [15:0] T_PIN        = 16'h1234;
    localparam int unsigned T_MAX_FAILS  = 3;
    localparam int unsigned T_LOCKOUT    = 1024;
    localparam int unsigned T_TIMEOUT    = 4096;

    logic clk;
    logic rst_n;
    logic ena;

    alarm_keypad_ctrl_if kp ();

    alarm_keypad_ctrl #(
        .PIN_DIGITS     (T_PIN_DIGITS),
        .PIN            (T_PIN),
        .MAX_FAILS      (T_MAX_FAILS),
        .LOCKOUT_CYCLES (T_LOCKOUT),
        .ENTRY_TIMEOUT  (T_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .kp    (kp.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: digits typed so far, idle-cycle count, lockout countdown.
    int   m_digits[$];
    bit   m_entering;
    bit   m_check;
    int   m_idle;
    int   m_lock_left;
    int   m_fails;
    bit   m_arm;
    bit   m_disarm;

    task automatic model_reset();
        m_digits.delete();
        m_entering  = 0;
        m_check     = 0;
        m_idle      = 0;
        m_lock_left = 0;
        m_fails     = 0;
        m_arm       = 0;
        m_disarm    = 0;
    endtask

    function automatic bit pin_matches();
        if (m_digits.size() != int'(T_PIN_DIGITS)) return 0;
        for (int i = 0; i < int'(T_PIN_DIGITS); i++) begin
            int want;
            want = int'((T_PIN >> (4 * (int'(T_PIN_DIGITS) - 1 - i))) & 16'hF);
            if (m_digits[i] != want) return 0;
        end
        return 1;
    endfunction

    task automatic model_step(input bit v, input int code, input bit armed, input bit en);
        m_arm    = 0;
        m_disarm = 0;
        if (!en) return;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_check) begin
            m_check = 0;
            if (pin_matches()) begin
                m_fails = 0;
                if (armed) m_disarm = 1; else m_arm = 1;
            end else begin
                m_fails++;
                if (m_fails == int'(T_MAX_FAILS)) m_lock_left = int'(T_LOCKOUT);
            end
            m_digits.delete();
        end else if (m_entering) begin
            if (v) begin
                m_idle = 0;
                if (code <= 9) begin
                    if (m_digits.size() <= int'(T_PIN_DIGITS)) m_digits.push_back(code);
                end else if (code == 10) begin
                    m_entering = 0;
                    m_check    = 1;
                end else if (code == 11) begin
                    m_entering = 0;
                    m_digits.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == int'(T_TIMEOUT)) begin
                    m_entering = 0;
                    m_digits.delete();
                end
            end
        end else if (v && code <= 9) begin
            m_entering = 1;
            m_idle     = 0;
            m_digits.delete();
            m_digits.push_back(code);
        end
    endtask

    bit          armed_v;
    bit          ena_v;
    int unsigned arm_seen;
    int unsigned disarm_seen;
    int unsigned lock_seen;

    // One clock: drive inputs, advance model at the edge, compare at the falling edge.
    task automatic step(input bit v, input logic [3:0] c);
        kp.key_valid = v;
        kp.key_code  = c;
        kp.sys_armed = armed_v;
        ena          = ena_v;
        @(posedge clk);
        model_step(v, int'(c), armed_v, ena_v);
        @(negedge clk);
        check_eq("arm_req",      32'(kp.arm_req),      32'(m_arm));
        check_eq("disarm_req",   32'(kp.disarm_req),   32'(m_disarm));
        check_eq("entry_active", 32'(kp.entry_active), 32'(m_entering));
        check_eq("locked_out",   32'(kp.locked_out),   32'(m_lock_left > 0));
        check_eq("fail_cnt",     32'(kp.fail_cnt),     32'(m_fails));
        if (kp.arm_req)    arm_seen++;
        if (kp.disarm_req) disarm_seen++;
        if (kp.locked_out) lock_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0);
    endtask

    task automatic press(input logic [3:0] c);
        step(1'b1, c);
        idle(int'($urandom_range(0, 2)));
    endtask

    task automatic press_pin(input bit good);
        press(4'h1); press(4'h2); press(4'h3); press(good ? 4'h4 : 4'h5); press(4'hA);
    endtask

    task automatic clear_seen();
        arm_seen    = 0;
        disarm_seen = 0;
        lock_seen   = 0;
    endtask

    initial begin
        rst_n        = 1'b1;
        ena          = 1'b1;
        ena_v        = 1'b1;
        armed_v      = 1'b0;
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h0;
        kp.sys_armed = 1'b0;
        model_reset();
        clear_seen();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_arm",    32'(kp.arm_req),      0);
        check_eq("rst_disarm", 32'(kp.disarm_req),   0);
        check_eq("rst_entry",  32'(kp.entry_active), 0);
        check_eq("rst_locked", 32'(kp.locked_out),   0);
        check_eq("rst_fail",   32'(kp.fail_cnt),     0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // 1: correct PIN while disarmed -> single arm pulse two edges after ENTER.
        clear_seen();
        armed_v = 0;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        step(1'b1, 4'hA);
        check_eq("s1_check_cycle_arm", 32'(kp.arm_req), 0);
        step(1'b0, 4'h0);
        check_eq("s1_arm_at_k1", 32'(kp.arm_req), 1);
        step(1'b0, 4'h0);
        check_eq("s1_arm_one_cycle", 32'(kp.arm_req), 0);
        check_eq("s1_arm_cnt", arm_seen, 1);
        check_eq("s1_fail", 32'(kp.fail_cnt), 0);

        // 2: correct PIN while armed -> disarm only.
        clear_seen();
        armed_v = 1;
        press_pin(1); idle(3);
        check_eq("s2_disarm_cnt", disarm_seen, 1);
        check_eq("s2_arm_cnt", arm_seen, 0);
        armed_v = 0;

        // 3: three wrong codes -> lockout; keys during lockout ignored.
        clear_seen();
        press_pin(0); idle(2);
        check_eq("s3_fail1", 32'(kp.fail_cnt), 1);
        press_pin(0); idle(2);
        check_eq("s3_fail2", 32'(kp.fail_cnt), 2);
        press_pin(0); idle(2);
        check_eq("s3_fail3", 32'(kp.fail_cnt), 3);
        check_eq("s3_locked", 32'(kp.locked_out), 1);
        press_pin(1);
        for (int i = 0; i < 1200 && kp.locked_out; i++) step(1'b0, 4'h0);
        check_eq("s3_unlocked", 32'(kp.locked_out), 0);
        check_eq("s3_lock_len", lock_seen, T_LOCKOUT);
        check_eq("s3_no_req", arm_seen + disarm_seen, 0);
        check_eq("s3_fail_clr", 32'(kp.fail_cnt), 0);

        // 4: overflow and short code mismatch, then CLEAR recovery.
        clear_seen();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hA); idle(2);
        check_eq("s4_ovf_fail", 32'(kp.fail_cnt), 1);
        press(4'h1); press(4'h2); press(4'hA); idle(2);
        check_eq("s4_short_fail", 32'(kp.fail_cnt), 2);
        press(4'h1); press(4'h2); press(4'hB);
        press_pin(1); idle(2);
        check_eq("s4_arm_cnt", arm_seen, 1);
        check_eq("s4_fail_clr", 32'(kp.fail_cnt), 0);

        // 5: entry timeout is not a failure; remaining digits form a bad code.
        press(4'h1); press(4'h2);
        idle(int'(T_TIMEOUT));
        check_eq("s5_timeout", 32'(kp.entry_active), 0);
        check_eq("s5_fail_keep", 32'(kp.fail_cnt), 0);
        press(4'h3); press(4'h4); press(4'hA); idle(2);
        check_eq("s5_mismatch", 32'(kp.fail_cnt), 1);

        // 6: ena low freezes the entry timer; then reset mid-entry.
        clear_seen();
        press(4'h1);
        ena_v = 0;
        idle(5000);
        ena_v = 1;
        check_eq("s6_still_entry", 32'(kp.entry_active), 1);
        press(4'h2); press(4'h3); press(4'h4); press(4'hA); idle(2);
        check_eq("s6_arm_cnt", arm_seen, 1);
        check_eq("s6_fail_clr", 32'(kp.fail_cnt), 0);
        press(4'h1); press(4'h2);
        check_eq("s6_pre_rst_entry", 32'(kp.entry_active), 1);
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_entry", 32'(kp.entry_active), 0);
        check_eq("s6_rst_fail",  32'(kp.fail_cnt), 0);
        check_eq("s6_rst_req",   32'(kp.arm_req | kp.disarm_req), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int unsigned sel;
            sel     = $urandom_range(0, 9);
            armed_v = 1'($urandom_range(0, 1));
            if (sel < 4) begin
                press_pin(1);
            end else if (sel < 7) begin
                int unsigned len;
                len = $urandom_range(1, 5);
                for (int j = 0; j < int'(len); j++) press(4'($urandom_range(0, 9)));
                press(4'hA);
            end else if (sel == 7) begin
                press(4'($urandom_range(0, 9)));
                press(4'($urandom_range(10, 15)));
            end else if (sel == 8) begin
                ena_v = 0;
                press(4'($urandom_range(0, 15)));
                idle(int'($urandom_range(1, 5)));
                ena_v = 1;
            end else begin
                press(4'($urandom_range(0, 15)));
            end
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
